e203_cg_sched: RTL and testbench

Clock-gating scheduler for the core's gated clock domains (IFU, EXU, LSU, BIU, ...). It produces one clock-enable per domain to drive the `e203_clkgate` cells. Each enable has a programmable idle hysteresis, so a domain keeps its clock for `hold_cfg` cycles after it goes inactive. A sleep FSM sequences WFI entry and exit: it drains the non-fetch domains, gates the fetch domain (domain 0), and reports sleep to the CSR/debug logic.

---
 rtl/e203_cg_sched.sv | 114 +++++++++++
 tb/tb_e203_cg_sched.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/e203_cg_sched.sv
// e203_cg_sched
//
// Clock-gating scheduler for the core's gated clock domains. Produces one
// clock enable per domain for the clock-gate cells, each with a programmable
// idle hysteresis, and sequences WFI sleep entry/exit for the fetch domain.
//
// Ports:
//   clk        in          core clock (ungated)
//   rst        in          synchronous active-high reset
//   cgstop     in          mcgstop CSR bit; forces every enable high
//   hold_cfg   in  HOLD_W  idle cycles a domain keeps its clock after activity drops
//   dom_active in  NDOM    per-domain activity (bit 0 = fetch domain)
//   dom_clk_en out NDOM    per-domain clock enable
//   sleep_req  in          WFI committed (level)
//   wake_evt   in          wake source: interrupt or debug request (level)
//   sleep_ack  out         core is asleep (registered)
//   all_idle   out         no domain active and every hysteresis counter zero

module e203_cg_sched #(
  parameter int NDOM   = 4,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cgstop,
  input  logic [HOLD_W-1:0] hold_cfg,
  input  logic [NDOM-1:0]   dom_active,
  output logic [NDOM-1:0]   dom_clk_en,
  input  logic              sleep_req,
  input  logic              wake_evt,
  output logic              sleep_ack,
  output logic              all_idle
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              sleep_ack_q, sleep_ack_d;
  logic [HOLD_W-1:0] cnt_q [NDOM];
  logic [HOLD_W-1:0] cnt_d [NDOM];
  logic [NDOM-1:0]   cnt_nz;

  // Sleep sequencing. A wake event always wins over a pending sleep request,
  // and DRAIN only waits on the non-fetch domains' live activity.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (sleep_req && !wake_evt) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wake_evt || !sleep_req)            state_d = ST_RUN;
        else if (dom_active[NDOM-1:1] == '0)   state_d = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (wake_evt) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    sleep_ack_d = (state_d == ST_SLEEP);
  end

  // Hysteresis counters. hold_cfg is only sampled on load so a reprogram
  // never disturbs a countdown already running. The fetch counter is
  // cleared while asleep and reloaded on wake so fetch gets a full hold
  // window after resuming.
  always_comb begin
    for (int i = 0; i < NDOM; i++) begin
      if (dom_active[i])        cnt_d[i] = hold_cfg;
      else if (cnt_q[i] != '0)  cnt_d[i] = cnt_q[i] - HOLD_W'(1);
      else                      cnt_d[i] = '0;
    end
    if (state_q == ST_SLEEP)     cnt_d[0] = '0;
    else if (state_q == ST_WAKE) cnt_d[0] = hold_cfg;
  end

  // Enables are combinational from registered counters plus live inputs so
  // a domain regains its clock in the same cycle it becomes active. The
  // sleep override on domain 0 beats activity and the counter, but not cgstop.
  always_comb begin
    for (int i = 0; i < NDOM; i++) begin
      cnt_nz[i]     = (cnt_q[i] != '0);
      dom_clk_en[i] = cgstop | dom_active[i] | cnt_nz[i];
    end
    if (state_q == ST_SLEEP)     dom_clk_en[0] = cgstop;
    else if (state_q == ST_WAKE) dom_clk_en[0] = 1'b1;
    all_idle = ~|dom_active & ~|cnt_nz;
  end

  // Counters reset to all-ones so every domain runs a full hold window
  // after reset regardless of hold_cfg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      sleep_ack_q <= 1'b0;
      for (int i = 0; i < NDOM; i++) cnt_q[i] <= '1;
    end else begin
      state_q     <= state_d;
      sleep_ack_q <= sleep_ack_d;
      for (int i = 0; i < NDOM; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sleep_ack = sleep_ack_q;

endmodule

// File: tb/tb_e203_cg_sched.sv
// tb_e203_cg_sched
//
// Directed-vector bench for e203_cg_sched. Each stimulus cycle pushes its
// hand-computed expected outputs into a queue; a monitor on the falling edge
// pops one entry per cycle and compares it against the DUT outputs.

module tb_e203_cg_sched;

  logic       clk;
  logic       rst;
  logic       cgstop;
  logic [3:0] hold_cfg;
  logic [3:0] dom_active;
  logic [3:0] dom_clk_en;
  logic       sleep_req;
  logic       wake_evt;
  logic       sleep_ack;
  logic       all_idle;

  typedef struct {
    logic [3:0] en;
    logic       ack;
    logic       idle;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks_total;
  int   checks_passed;

  e203_cg_sched #(.NDOM(4), .HOLD_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cgstop     (cgstop),
    .hold_cfg   (hold_cfg),
    .dom_active (dom_active),
    .dom_clk_en (dom_clk_en),
    .sleep_req  (sleep_req),
    .wake_evt   (wake_evt),
    .sleep_ack  (sleep_ack),
    .all_idle   (all_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs just after the rising edge and queues the
  // outputs expected during that cycle.
  task automatic applyStimulus(input logic r, input logic [3:0] act,
                               input logic sreq, input logic wk,
                               input logic cg, input logic [3:0] hold,
                               input logic [3:0] e_en, input logic e_ack,
                               input logic e_idle, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = r;
    dom_active = act;
    sleep_req  = sreq;
    wake_evt   = wk;
    cgstop     = cg;
    hold_cfg   = hold;
    e.en   = e_en;
    e.ack  = e_ack;
    e.idle = e_idle;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string nm, input logic [3:0] got,
                             input logic [3:0] want);
    checks_total++;
    if (got === want) checks_passed++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
  endtask

  // Monitor: one expected entry per stimulus cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checkOutput({mon_e.name, ".dom_clk_en"}, dom_clk_en, mon_e.en);
      checkOutput({mon_e.name, ".sleep_ack"}, {3'b0, sleep_ack}, {3'b0, mon_e.ack});
      checkOutput({mon_e.name, ".all_idle"}, {3'b0, all_idle}, {3'b0, mon_e.idle});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst        = 1'b1;
    cgstop     = 1'b0;
    hold_cfg   = 4'd3;
    dom_active = 4'h0;
    sleep_req  = 1'b0;
    wake_evt   = 1'b0;

    // Reset held: counters all-ones, RUN, no ack.
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 4'h0, 0, 0, 0, 4'd3, 4'hF, 0, 0, "reset");
    // 15 cycles of post-reset hold, then everything gates off.
    for (int i = 0; i < 15; i++)
      applyStimulus(0, 4'h0, 0, 0, 0, 4'd3, 4'hF, 0, 0, "post_reset_hold");
    applyStimulus(0, 4'h0, 0, 0, 0, 4'd3, 4'h0, 0, 1, "post_reset_expire");
    applyStimulus(0, 4'h0, 0, 0, 0, 4'd3, 4'h0, 0, 1, "idle_steady");

    // One-cycle pulse on domain 2 with hold 3, then with hold 0.
    applyStimulus(0, 4'b0100, 0, 0, 0, 4'd3, 4'b0100, 0, 0, "pulse_h3_t");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 4'h0, 0, 0, 0, 4'd3, 4'b0100, 0, 0, "pulse_h3_hold");
    applyStimulus(0, 4'h0, 0, 0, 0, 4'd3, 4'h0, 0, 1, "pulse_h3_off");
    applyStimulus(0, 4'b0100, 0, 0, 0, 4'd0, 4'b0100, 0, 0, "pulse_h0_t");
    applyStimulus(0, 4'h0, 0, 0, 0, 4'd0, 4'h0, 0, 1, "pulse_h0_off");

    // Sleep entry with fetch active, then wake.
    applyStimulus(0, 4'b0001, 1, 0, 0, 4'd3, 4'b0001, 0, 0, "sleep_run");
    applyStimulus(0, 4'b0001, 1, 0, 0, 4'd3, 4'b0001, 0, 0, "sleep_drain");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 4'b0001, 1, 0, 0, 4'd3, 4'h0, 1, 0, "sleep_gated");
    applyStimulus(0, 4'b0001, 1, 1, 0, 4'd3, 4'h0, 1, 0, "sleep_wake_req");
    applyStimulus(0, 4'h0, 0, 0, 0, 4'd3, 4'b0001, 0, 1, "wake_state");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 4'h0, 0, 0, 0, 4'd3, 4'b0001, 0, 0, "wake_hold");
    applyStimulus(0, 4'h0, 0, 0, 0, 4'd3, 4'h0, 0, 1, "wake_expire");

    // DRAIN stalls on domain 1, abort by wake, then re-entry takes 2 cycles.
    applyStimulus(0, 4'b0010, 1, 0, 0, 4'd3, 4'b0010, 0, 0, "drain_enter");
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 4'b0010, 1, 0, 0, 4'd3, 4'b0010, 0, 0, "drain_stall");
    applyStimulus(0, 4'b0010, 1, 1, 0, 4'd3, 4'b0010, 0, 0, "drain_abort");
    applyStimulus(0, 4'h0, 1, 0, 0, 4'd3, 4'b0010, 0, 0, "reenter_run");
    applyStimulus(0, 4'h0, 1, 0, 0, 4'd3, 4'b0010, 0, 0, "reenter_drain");
    applyStimulus(0, 4'h0, 1, 0, 0, 4'd3, 4'b0010, 1, 0, "reenter_sleep");
    applyStimulus(0, 4'h0, 1, 0, 0, 4'd3, 4'h0, 1, 1, "sleep_idle");

    // cgstop while asleep: all enables up at once, ack unaffected.
    for (int i = 0; i < 2; i++)
      applyStimulus(0, 4'h0, 1, 0, 1, 4'd3, 4'hF, 1, 1, "cgstop_sleep");
    applyStimulus(0, 4'h0, 1, 0, 0, 4'd3, 4'h0, 1, 1, "cgstop_release");
    applyStimulus(0, 4'h0, 0, 1, 0, 4'd3, 4'h0, 1, 1, "wake_req2");
    applyStimulus(0, 4'h0, 0, 0, 0, 4'd3, 4'b0001, 0, 1, "wake2");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 4'h0, 0, 0, 0, 4'd3, 4'b0001, 0, 0, "wake2_hold");
    applyStimulus(0, 4'h0, 0, 0, 0, 4'd3, 4'h0, 0, 1, "wake2_expire");

    // sleep_req and wake_evt together in RUN must not leave RUN.
    applyStimulus(0, 4'h0, 1, 1, 0, 4'd3, 4'h0, 0, 1, "req_wake_tie");
    applyStimulus(0, 4'h0, 1, 0, 0, 4'd3, 4'h0, 0, 1, "tie_run");
    applyStimulus(0, 4'h0, 1, 0, 0, 4'd3, 4'h0, 0, 1, "tie_drain");
    applyStimulus(0, 4'h0, 1, 0, 0, 4'd3, 4'h0, 1, 1, "tie_sleep");

    // Reset while asleep returns everything to reset values.
    applyStimulus(1, 4'h0, 1, 0, 0, 4'd3, 4'h0, 1, 1, "rst_in_sleep");
    for (int i = 0; i < 15; i++)
      applyStimulus(0, 4'h0, 0, 0, 0, 4'd3, 4'hF, 0, 0, "rst_recover");
    applyStimulus(0, 4'h0, 0, 0, 0, 4'd3, 4'h0, 0, 1, "rst_recover_expire");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    checks_total++;
    if (exp_q.size() == 0) checks_passed++;
    else $display("[TB] FAIL drain_queue: %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
